// File: rtl/dcm_lock_monitor.sv
// Frequency/lock checker for a DCM-derived clock, measured in clk2x cycles per REF_WINDOW edges.
// Optional min/max history of published counts is built when DCM_LOCK_MONITOR_HIST_EN is defined.
module dcm_lock_monitor #(
  parameter int REF_WINDOW   = 16,
  parameter int EXPECT_COUNT = 64,
  parameter int TOLERANCE    = 1,
  parameter int LOCK_WINDOWS = 4,
  parameter int STALL_LIMIT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clk2x,
  input  logic             resetb,
  input  logic             mon_clk,
  input  logic             enable,
  output logic             locked,
  output logic             stalled,
  output logic             count_valid,
  output logic [CNT_W-1:0] measured_count,
  output logic [7:0]       err_count,
  output logic [7:0]       status,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count
);
  localparam int EW = $clog2(REF_WINDOW + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [EW-1:0]    LAST_EDGE  = EW'(REF_WINDOW - 1);
  localparam logic [GW-1:0]    GOOD_MAX   = GW'(LOCK_WINDOWS);
  localparam logic [SW-1:0]    STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [SW-1:0]    STALL_MAX  = SW'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] EXPECT     = CNT_W'(EXPECT_COUNT);
  localparam logic [CNT_W-1:0] TOL        = CNT_W'(TOLERANCE);

  typedef enum logic [1:0] {IDLE = 2'b00, ARM = 2'b01, MEASURE = 2'b10} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  // An all-ones count means the window overflowed and can never be good.
  function automatic logic win_good(input logic [CNT_W-1:0] cnt);
    return (cnt != '1) && (abs_diff(cnt, EXPECT) <= TOL);
  endfunction

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             mon_rise;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [GW-1:0]    good_q, good_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             locked_q, locked_d;
  logic             stalled_q, stalled_d;
  logic [CNT_W-1:0] meas_q, meas_d;
  logic [7:0]       err_q, err_d;
  logic             close_vld_p1_q, close_vld_p1_d;
  logic             cv_q, cv_d;

  assign mon_rise = s2_q & ~s3_q;

  always_comb begin
    state_d        = state_q;
    cyc_d          = cyc_q;
    edge_d         = edge_q;
    good_d         = good_q;
    stall_d        = stall_q;
    locked_d       = locked_q;
    stalled_d      = stalled_q;
    meas_d         = meas_q;
    err_d          = err_q;
    close_vld_p1_d = 1'b0;
    cv_d           = 1'b0;

    case (state_q)
      IDLE: if (enable) state_d = ARM;
      ARM: begin
        if (mon_rise) begin
          cyc_d   = '0;
          edge_d  = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cyc_d = sat_inc(cyc_q);
        if (mon_rise) begin
          if (edge_q == LAST_EDGE) begin
            // Closing edge doubles as the next window's start edge.
            meas_d         = sat_inc(cyc_q);
            close_vld_p1_d = 1'b1;
            cyc_d          = '0;
            edge_d         = '0;
          end else begin
            edge_d = edge_q + EW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Judge the window one cycle after it is captured, alongside count_valid.
    if (close_vld_p1_q) begin
      cv_d = 1'b1;
      if (win_good(meas_q)) begin
        good_d   = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);
        locked_d = (good_d == GOOD_MAX);
      end else begin
        good_d   = '0;
        locked_d = 1'b0;
        if (err_q != 8'hFF) err_d = err_q + 8'd1;
      end
    end

    if (state_q != IDLE) begin
      if (mon_rise) begin
        stall_d   = '0;
        stalled_d = 1'b0;
      end else begin
        if (stall_q != STALL_MAX) stall_d = stall_q + SW'(1);
        if (stall_q == STALL_LAST) begin
          stalled_d = 1'b1;
          locked_d  = 1'b0;
          good_d    = '0;
          state_d   = ARM;
        end
      end
    end

    if (!enable) begin
      state_d        = IDLE;
      cyc_d          = '0;
      edge_d         = '0;
      good_d         = '0;
      stall_d        = '0;
      locked_d       = 1'b0;
      stalled_d      = 1'b0;
      meas_d         = meas_q;
      err_d          = err_q;
      close_vld_p1_d = 1'b0;
      cv_d           = 1'b0;
    end
  end

  always_ff @(posedge clk2x or negedge resetb) begin
    if (!resetb) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= IDLE;
      cyc_q          <= '0;
      edge_q         <= '0;
      good_q         <= '0;
      stall_q        <= '0;
      locked_q       <= 1'b0;
      stalled_q      <= 1'b0;
      meas_q         <= '0;
      err_q          <= '0;
      close_vld_p1_q <= 1'b0;
      cv_q           <= 1'b0;
    end else begin
      s1_q           <= mon_clk;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      state_q        <= state_d;
      cyc_q          <= cyc_d;
      edge_q         <= edge_d;
      good_q         <= good_d;
      stall_q        <= stall_d;
      locked_q       <= locked_d;
      stalled_q      <= stalled_d;
      meas_q         <= meas_d;
      err_q          <= err_d;
      close_vld_p1_q <= close_vld_p1_d;
      cv_q           <= cv_d;
    end
  end

`ifdef DCM_LOCK_MONITOR_HIST_EN
  logic [CNT_W-1:0] min_q, max_q;
  logic             hist_vld_q;

  always_ff @(posedge clk2x or negedge resetb) begin
    if (!resetb) begin
      min_q      <= '0;
      max_q      <= '0;
      hist_vld_q <= 1'b0;
    end else if (cv_d) begin
      if (!hist_vld_q || (meas_q < min_q)) min_q <= meas_q;
      if (!hist_vld_q || (meas_q > max_q)) max_q <= meas_q;
      hist_vld_q <= 1'b1;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`else
  assign min_count = '0;
  assign max_count = '0;
`endif

  assign locked         = locked_q;
  assign stalled        = stalled_q;
  assign count_valid    = cv_q;
  assign measured_count = meas_q;
  assign err_count      = err_q;
  assign status         = {3'b000, state_q, (err_q != 8'd0), stalled_q, locked_q};
endmodule
